// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and a
// variable-latency instruction memory.
//   IM_Req   : fetch request, held until acknowledged (fetch -> memory)
//   IM_Addr  : word-aligned fetch address, stable while IM_Req is high
//   IM_Ack   : one-cycle acknowledge pulse (memory -> fetch)
//   IM_Rdata : instruction word, valid in the IM_Ack cycle
interface fetch_unit_if;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack;
  logic [31:0] IM_Rdata;

  modport master (
    output IM_Req,
    output IM_Addr,
    input  IM_Ack,
    input  IM_Rdata
  );

  modport slave (
    input  IM_Req,
    input  IM_Addr,
    output IM_Ack,
    output IM_Rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the request/acknowledge
// handshake with instruction memory and offers one instruction at a time to
// the IF/ID register. A NOP is offered whenever no fetched word is ready.
// Branch redirects from D are applied to the PC only once the delay slot has
// been delivered; a redirect seen during a stall is remembered until then.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   En_D            : IF/ID capture enable (low = stall)
//   Branch_Taken    : D-stage redirect request
//   Branch_Target   : redirect target (bits [1:0] ignored)
//   im              : instruction-memory bus (master side)
//   PC_F            : PC of the offered instruction
//   Instruction_F   : offered instruction or NOP_INSTR
//   Fetch_Valid     : Instruction_F holds a real fetched word
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En_D,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  fetch_unit_if.master      im,
  output logic [31:0]       PC_F,
  output logic [31:0]       Instruction_F,
  output logic              Fetch_Valid
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] hold_instr_r;
  logic        redir_pend_r;
  logic [31:0] redir_target_r;

  logic        offer_valid_s;
  logic [31:0] offer_instr_s;
  logic        deliver_s;
  logic [31:0] branch_tgt_s;
  logic [31:0] next_pc_s;

  // Request side comes straight from registers: no request while holding.
  assign im.IM_Req  = (state_r == FETCH);
  assign im.IM_Addr = pc_r;

  assign PC_F          = pc_r;
  assign Instruction_F = offer_instr_s;
  assign Fetch_Valid   = offer_valid_s;

  // Masking keeps every PC word-aligned regardless of the target's low bits.
  assign branch_tgt_s = Branch_Target & 32'hFFFF_FFFC;
  assign deliver_s    = offer_valid_s & En_D;

  // Offer selection: acked word bypasses straight through in FETCH; an ack
  // arriving while holding is a protocol violation and is ignored.
  always_comb begin
    offer_valid_s = 1'b0;
    offer_instr_s = NOP_INSTR;
    case (state_r)
      FETCH: begin
        if (im.IM_Ack) begin
          offer_valid_s = 1'b1;
          offer_instr_s = im.IM_Rdata;
        end else begin
          offer_valid_s = 1'b0;
          offer_instr_s = NOP_INSTR;
        end
      end
      HOLD: begin
        offer_valid_s = 1'b1;
        offer_instr_s = hold_instr_r;
      end
      default: begin
        offer_valid_s = 1'b0;
        offer_instr_s = NOP_INSTR;
      end
    endcase
  end

  // Next PC after a delivery: a live branch beats a remembered one.
  always_comb begin
    next_pc_s = pc_r + 32'd4;
    if (Branch_Taken) begin
      next_pc_s = branch_tgt_s;
    end else if (redir_pend_r) begin
      next_pc_s = redir_target_r;
    end else begin
      next_pc_s = pc_r + 32'd4;
    end
  end

  // Fetch FSM with PC, held instruction and pending-redirect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= FETCH;
      pc_r           <= RESET_PC;
      hold_instr_r   <= NOP_INSTR;
      redir_pend_r   <= 1'b0;
      redir_target_r <= 32'h0000_0000;
    end else if (deliver_s) begin
      // Delay slot consumed: advance and start the next request next cycle.
      state_r      <= FETCH;
      pc_r         <= next_pc_s;
      redir_pend_r <= 1'b0;
    end else begin
      if (Branch_Taken) begin
        redir_pend_r   <= 1'b1;
        redir_target_r <= branch_tgt_s;
      end
      case (state_r)
        FETCH: begin
          if (im.IM_Ack) begin
            state_r      <= HOLD;
            hold_instr_r <= im.IM_Rdata;
          end
        end
        HOLD: begin
          state_r <= HOLD;
        end
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall / branch / memory-latency traffic, checked each cycle against a
// transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        En_D;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic [31:0] PC_F;
  logic [31:0] Instruction_F;
  logic        Fetch_Valid;

  fetch_unit_if im_bus ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .En_D          (En_D),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .im            (im_bus.master),
    .PC_F          (PC_F),
    .Instruction_F (Instruction_F),
    .Fetch_Valid   (Fetch_Valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model of the fetch stream: address of the next instruction to deliver,
  // whether its word has already arrived, and any remembered redirect.
  logic [31:0] m_pc;
  bit          m_have;
  logic [31:0] m_word;
  bit          m_pend;
  logic [31:0] m_target;
  int          wait_left;

  // Memory contents: a distinct, non-zero word per address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_have    = 1'b0;
    m_word    = NOP_INSTR;
    m_pend    = 1'b0;
    m_target  = 32'h0000_0000;
    wait_left = 0;
  endtask

  // One clock cycle, entered and left at a negative edge.
  // ack_mode: 0 = no ack, 1 = ack, 2 = memory model with random latency.
  task automatic step(input bit en, input bit br, input logic [31:0] tgt, input int ack_mode);
    bit          ack;
    bit          valid;
    bit          deliver;
    logic [31:0] exp_instr;
    if (ack_mode == 2) begin
      if (!m_have) begin
        ack = (wait_left == 0);
        if (!ack) wait_left--;
      end else begin
        ack = ($urandom_range(9, 0) == 0);
      end
    end else begin
      ack = (ack_mode == 1);
    end
    En_D            = en;
    Branch_Taken    = br;
    Branch_Target   = tgt;
    im_bus.IM_Ack   = ack;
    im_bus.IM_Rdata = (ack && !m_have) ? word_of(im_bus.IM_Addr) : $urandom;
    #1;
    valid     = m_have || ack;
    exp_instr = m_have ? m_word : (ack ? word_of(m_pc) : NOP_INSTR);
    chk("im_req", {31'd0, im_bus.IM_Req}, {31'd0, !m_have});
    if (!m_have) chk("im_addr", im_bus.IM_Addr, m_pc);
    chk("pc_f", PC_F, m_pc);
    chk("fetch_valid", {31'd0, Fetch_Valid}, {31'd0, valid});
    chk("instruction_f", Instruction_F, exp_instr);
    deliver = valid && en;
    if (deliver) begin
      if (br)          m_pc = tgt & 32'hFFFF_FFFC;
      else if (m_pend) m_pc = m_target;
      else             m_pc = m_pc + 32'd4;
      m_pend    = 1'b0;
      m_have    = 1'b0;
      wait_left = $urandom_range(3, 0);
    end else begin
      if (br) begin
        m_pend   = 1'b1;
        m_target = tgt & 32'hFFFF_FFFC;
      end
      if (ack && !m_have) begin
        m_have = 1'b1;
        m_word = word_of(m_pc);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, im_bus.IM_Req}, 32'd1);
    chk({tag, "_addr"},  im_bus.IM_Addr, RESET_PC);
    chk({tag, "_valid"}, {31'd0, Fetch_Valid}, 32'd0);
    chk({tag, "_instr"}, Instruction_F, NOP_INSTR);
    chk({tag, "_pc"},    PC_F, RESET_PC);
  endtask

  initial begin
    reset           = 1'b0;
    En_D            = 1'b0;
    Branch_Taken    = 1'b0;
    Branch_Target   = 32'h0000_0000;
    im_bus.IM_Ack   = 1'b0;
    im_bus.IM_Rdata = 32'h0000_0000;
    model_reset();

    // Reset state.
    @(negedge clk);
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait streaming.
    step(1'b1, 1'b0, 32'h0, 1);
    step(1'b1, 1'b0, 32'h0, 1);

    // Slow memory (ack on third cycle) with redirect latched while the delay
    // slot at 0x3008 waits; branch drops before the ack.
    step(1'b1, 1'b1, 32'h0000_3100, 0);
    step(1'b1, 1'b0, 32'h0, 0);
    step(1'b1, 1'b0, 32'h0, 1);
    chk("pending_redirect_addr", im_bus.IM_Addr, 32'h0000_3100);

    // Stall: ack with En_D low, hold three cycles (one spurious ack), release.
    step(1'b0, 1'b0, 32'h0, 1);
    step(1'b0, 1'b0, 32'h0, 0);
    step(1'b0, 1'b0, 32'h0, 1);
    step(1'b1, 1'b0, 32'h0, 0);
    chk("stall_release_addr", im_bus.IM_Addr, 32'h0000_3104);

    // Branch coincident with delivery; low target bits ignored.
    step(1'b1, 1'b1, 32'h0000_3206, 1);
    chk("coincident_branch_addr", im_bus.IM_Addr, 32'h0000_3204);

    // Live branch beats a remembered one.
    step(1'b0, 1'b1, 32'h0000_3300, 0);
    step(1'b1, 1'b1, 32'h0000_3400, 1);
    chk("live_beats_pending", im_bus.IM_Addr, 32'h0000_3400);

    // PC wrap at the top of the address space.
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1);
    step(1'b1, 1'b0, 32'h0, 1);
    chk("wrap_addr", im_bus.IM_Addr, 32'h0000_0000);

    // Random traffic.
    wait_left = $urandom_range(3, 0);
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, $urandom, 2);
    end

    // Reset asserted mid-run.
    En_D          = 1'b1;
    Branch_Taken  = 1'b0;
    im_bus.IM_Ack = 1'b0;
    reset         = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset_held");
    reset = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 32'h0, 1);
    wait_left = $urandom_range(3, 0);
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0, $urandom, 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
